// File: rtl/irq_ctrl_if.sv
// Signal bundle between the core (CSR file + trap FSM) and the interrupt pending/mask controller.
interface irq_ctrl_if;
    logic        pex_irq_i;
    logic        ptcmp_irq_i;
    logic        psoft_irq_i;
    logic        ext_edge_i;
    logic [31:0] mie_i;
    logic        trap_in_i;
    logic        pex_trap_rsp_i;
    logic        ptcmp_trap_rsp_i;
    logic        psoft_trap_rsp_i;
    logic        pex_trap_o;
    logic        ptcmp_trap_o;
    logic        psoft_trap_o;
    logic [31:0] mip_o;

    modport master (
        output pex_irq_i, ptcmp_irq_i, psoft_irq_i, ext_edge_i, mie_i, trap_in_i,
               pex_trap_rsp_i, ptcmp_trap_rsp_i, psoft_trap_rsp_i,
        input  pex_trap_o, ptcmp_trap_o, psoft_trap_o, mip_o
    );

    modport slave (
        input  pex_irq_i, ptcmp_irq_i, psoft_irq_i, ext_edge_i, mie_i, trap_in_i,
               pex_trap_rsp_i, ptcmp_trap_rsp_i, psoft_trap_rsp_i,
        output pex_trap_o, ptcmp_trap_o, psoft_trap_o, mip_o
    );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt pending/mask controller: syncs the external line, keeps MEIP/MTIP/MSIP, masks with mie
// and presents registered trap requests that freeze during a trap and stay off for a guard window.
module irq_ctrl #(
    parameter int EXT_SYNC_STAGES = 2,
    parameter int GUARD_CYCLES    = 2
) (
    input logic        clk,
    input logic        rst_n,
    irq_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    // Bit order used for pending, request and response vectors: {ext, timer, soft}
    logic [EXT_SYNC_STAGES-1:0] sync_q, sync_d;
    logic                       ext_s_d_q;
    logic                       ext_s, ext_rise;
    logic [2:0]                 pend_q, pend_d;
    logic [2:0]                 req, rsp;
    logic [2:0]                 trap_q, trap_d;
    logic [1:0]                 state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic                       unused_mie;

    assign sync_d   = {sync_q[EXT_SYNC_STAGES-2:0], bus.pex_irq_i};
    assign ext_s    = sync_q[EXT_SYNC_STAGES-1];
    assign ext_rise = ext_s & ~ext_s_d_q;

    assign rsp = {bus.pex_trap_rsp_i, bus.ptcmp_trap_rsp_i, bus.psoft_trap_rsp_i};
    assign req = pend_q & {bus.mie_i[11], bus.mie_i[7], bus.mie_i[3]};

    // In edge mode a new rise beats a simultaneous response so no edge is ever dropped
    always_comb begin
        pend_d    = pend_q;
        pend_d[0] = bus.psoft_irq_i;
        pend_d[1] = bus.ptcmp_irq_i;
        if (bus.ext_edge_i) pend_d[2] = ext_rise | (pend_q[2] & ~rsp[2]);
        else                pend_d[2] = ext_s;
    end

    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                trap_d = req;
                if (bus.trap_in_i) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!bus.trap_in_i) begin
                    state_d = ST_GUARD;
                    trap_d  = 3'b000;
                    cnt_d   = 4'(GUARD_CYCLES);
                end else begin
                    trap_d = trap_q & ~rsp;
                end
            end
            ST_GUARD: begin
                cnt_d = cnt_q - 4'd1;
                if (bus.trap_in_i) begin
                    state_d = ST_HOLD;
                    trap_d  = 3'b000;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    // Reload on the exit edge so the zero window is exactly GUARD_CYCLES long
                    state_d = ST_IDLE;
                    trap_d  = req;
                end else begin
                    trap_d = 3'b000;
                end
            end
            default: begin
                state_d = ST_IDLE;
                trap_d  = 3'b000;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            ext_s_d_q <= 1'b0;
            pend_q    <= 3'b000;
            trap_q    <= 3'b000;
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
        end else begin
            sync_q    <= sync_d;
            ext_s_d_q <= ext_s;
            pend_q    <= pend_d;
            trap_q    <= trap_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.pex_trap_o   = trap_q[2];
    assign bus.ptcmp_trap_o = trap_q[1];
    assign bus.psoft_trap_o = trap_q[0];
    assign bus.mip_o        = {20'b0, pend_q[2], 3'b0, pend_q[1], 3'b0, pend_q[0], 3'b0};

    assign unused_mie = ^{bus.mie_i[31:12], bus.mie_i[10:8], bus.mie_i[6:4], bus.mie_i[2:0]};

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic, all checked against a behavioural model.
module tb_irq_ctrl;
    localparam int ES = 2;
    localparam int GC = 2;

    logic clk = 1'b0;
    logic rst_n;
    irq_ctrl_if bus();

    irq_ctrl #(.EXT_SYNC_STAGES(ES), .GUARD_CYCLES(GC)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: pending {meip,mtip,msip}, visible request outputs, trap phase, history of line samples
    logic [2:0] m_pend, m_out;
    bit         m_frozen;
    int         m_guard;
    bit         hist[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_mip();
        return (32'(m_pend[2]) << 11) | (32'(m_pend[1]) << 7) | (32'(m_pend[0]) << 3);
    endfunction

    task automatic model_reset();
        m_pend   = 3'b000;
        m_out    = 3'b000;
        m_frozen = 1'b0;
        m_guard  = 0;
        hist.delete();
    endtask

    function automatic logic [31:0] dut_out();
        return 32'({bus.pex_trap_o, bus.ptcmp_trap_o, bus.psoft_trap_o});
    endfunction

    task automatic step();
        logic       pex_c, ptc_c, pso_c, edge_c, tin_c;
        logic [2:0] rsp_c, req, nxt;
        logic [31:0] mie_c;
        logic       es, esd, meip_n;
        pex_c  = bus.pex_irq_i;
        ptc_c  = bus.ptcmp_irq_i;
        pso_c  = bus.psoft_irq_i;
        edge_c = bus.ext_edge_i;
        tin_c  = bus.trap_in_i;
        mie_c  = bus.mie_i;
        rsp_c  = {bus.pex_trap_rsp_i, bus.ptcmp_trap_rsp_i, bus.psoft_trap_rsp_i};
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            // Line value seen ES and ES+1 edges ago (zero until the chain has refilled after reset)
            es  = (hist.size() > ES - 1) ? hist[ES-1] : 1'b0;
            esd = (hist.size() > ES)     ? hist[ES]   : 1'b0;
            req = m_pend & {mie_c[11], mie_c[7], mie_c[3]};
            meip_n = edge_c ? ((es & ~esd) | (m_pend[2] & ~rsp_c[2])) : es;
            if (m_frozen) begin
                if (!tin_c) begin
                    m_frozen = 1'b0;
                    m_guard  = GC;
                    nxt      = 3'b000;
                end else begin
                    nxt = m_out & ~rsp_c;
                end
            end else if (m_guard > 0) begin
                if (tin_c) begin
                    m_frozen = 1'b1;
                    m_guard  = 0;
                    nxt      = 3'b000;
                end else if (m_guard == 1) begin
                    m_guard = 0;
                    nxt     = req;
                end else begin
                    m_guard--;
                    nxt = 3'b000;
                end
            end else begin
                nxt = req;
                if (tin_c) m_frozen = 1'b1;
            end
            m_out  = nxt;
            m_pend = {meip_n, ptc_c, pso_c};
            hist.push_front(pex_c);
            if (hist.size() > ES + 1) void'(hist.pop_back());
        end
        #1;
        chk("trap_out", dut_out(), 32'(m_out));
        chk("mip", bus.mip_o, m_mip());
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async_out", dut_out(), 32'd0);
        chk("rst_async_mip", bus.mip_o, 32'd0);
        steps(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.pex_irq_i = 0; bus.ptcmp_irq_i = 0; bus.psoft_irq_i = 0;
        bus.ext_edge_i = 1; bus.mie_i = 32'h0; bus.trap_in_i = 0;
        bus.pex_trap_rsp_i = 0; bus.ptcmp_trap_rsp_i = 0; bus.psoft_trap_rsp_i = 0;
        model_reset();
        #3;
        chk("reset_out", dut_out(), 32'd0);
        chk("reset_mip", bus.mip_o, 32'd0);
        steps(2);
        rst_n = 1'b1;

        // 1: edge mode pulse, 4-edge latency, held until response
        bus.mie_i = 32'h800;
        steps(3);
        bus.pex_irq_i = 1; step();
        bus.pex_irq_i = 0; steps(2);
        chk("t1_before", 32'(bus.pex_trap_o), 32'd0);
        step();
        chk("t1_latency", 32'(bus.pex_trap_o), 32'd1);
        steps(4);
        chk("t1_held", 32'(bus.pex_trap_o), 32'd1);
        bus.pex_trap_rsp_i = 1; step();
        bus.pex_trap_rsp_i = 0; step();
        chk("t1_cleared", 32'(bus.pex_trap_o), 32'd0);

        // 2: level mode ignores response, drops 4 edges after line falls
        bus.ext_edge_i = 0; bus.pex_irq_i = 1; steps(5);
        bus.pex_trap_rsp_i = 1; step();
        bus.pex_trap_rsp_i = 0; step();
        chk("t2_rsp_ignored", 32'(bus.pex_trap_o), 32'd1);
        chk("t2_meip", bus.mip_o, 32'h800);
        bus.pex_irq_i = 0; steps(3);
        chk("t2_still_high", 32'(bus.pex_trap_o), 32'd1);
        step();
        chk("t2_dropped", 32'(bus.pex_trap_o), 32'd0);

        // 3: timer pending but masked, then unmasked
        bus.mie_i = 32'h0; bus.ptcmp_irq_i = 1; steps(2);
        chk("t3_mip", bus.mip_o, 32'h80);
        chk("t3_masked", 32'(bus.ptcmp_trap_o), 32'd0);
        bus.mie_i = 32'h80; step();
        chk("t3_unmasked", 32'(bus.ptcmp_trap_o), 32'd1);
        bus.mie_i = 32'h0; step();
        chk("t3_remask_out", 32'(bus.ptcmp_trap_o), 32'd0);
        chk("t3_remask_mip", bus.mip_o, 32'h80);
        bus.ptcmp_irq_i = 0; steps(2);

        // 4: freeze during trap, then exactly GC zero cycles
        bus.mie_i = 32'h8; bus.psoft_irq_i = 1; steps(3);
        bus.trap_in_i = 1;
        for (int i = 0; i < 5; i++) begin
            bus.psoft_irq_i = i[0];
            step();
            chk("t4_frozen", 32'(bus.psoft_trap_o), 32'd1);
        end
        bus.psoft_irq_i = 1; bus.trap_in_i = 0;
        step(); chk("t4_guard0", 32'(bus.psoft_trap_o), 32'd0);
        step(); chk("t4_guard1", 32'(bus.psoft_trap_o), 32'd0);
        step(); chk("t4_resume", 32'(bus.psoft_trap_o), 32'd1);
        bus.psoft_irq_i = 0; steps(3);

        // 5: rise coinciding with response keeps MEIP; spurious response clears it
        bus.ext_edge_i = 1; bus.mie_i = 32'h800;
        bus.pex_irq_i = 1; step();
        bus.pex_irq_i = 0; steps(3);
        chk("t5_pending", bus.mip_o, 32'h800);
        bus.pex_irq_i = 1; step();
        bus.pex_irq_i = 0; step();
        bus.pex_trap_rsp_i = 1; step();
        bus.pex_trap_rsp_i = 0;
        chk("t5_set_wins", bus.mip_o, 32'h800);
        steps(2);
        bus.pex_trap_rsp_i = 1; step();
        bus.pex_trap_rsp_i = 0;
        chk("t5_spurious_clr", bus.mip_o, 32'h0);
        steps(2);

        // 6: reset during HOLD with all sources active
        bus.ext_edge_i = 0; bus.mie_i = 32'h888;
        bus.pex_irq_i = 1; bus.ptcmp_irq_i = 1; bus.psoft_irq_i = 1;
        steps(5);
        bus.trap_in_i = 1; steps(3);
        chk("t6_hold_all", dut_out(), 32'd7);
        async_reset();
        bus.trap_in_i = 0; steps(2);
        chk("t6_idle_after", 32'(bus.ptcmp_trap_o), 32'd1);
        steps(4);
        chk("t6_all_again", dut_out(), 32'd7);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0)   bus.pex_irq_i   = ~bus.pex_irq_i;
            if ($urandom_range(0, 15) == 0)  bus.ptcmp_irq_i = ~bus.ptcmp_irq_i;
            if ($urandom_range(0, 15) == 0)  bus.psoft_irq_i = ~bus.psoft_irq_i;
            if ($urandom_range(0, 199) == 0) bus.ext_edge_i  = ~bus.ext_edge_i;
            if ($urandom_range(0, 40) == 0)  bus.mie_i       = $urandom;
            if ($urandom_range(0, 9) == 0)   bus.trap_in_i   = ~bus.trap_in_i;
            bus.pex_trap_rsp_i   = ($urandom_range(0, 5) == 0);
            bus.ptcmp_trap_rsp_i = ($urandom_range(0, 5) == 0);
            bus.psoft_trap_rsp_i = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 599) == 0) async_reset();
            else step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
